// File: rtl/muller_c_pkg.sv
// muller_c_pkg
// Shared definitions for the Muller C-element driver:
//   - state_e      : driver FSM states
//   - step_t       : one entry of the 4-step input sequence (a, b, expected c, hold flag)
//   - step_lookup  : the step table, with optional a/b swap for b-leads order
//   - MODE_*_BIT   : bit positions inside mode_i
package muller_c_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StWait,
        StCheck,
        StEnd
    } state_e;

    typedef struct packed {
        logic a;
        logic b;
        logic exp_c;
        logic hold;   // 1: output must not move; 0: output must transition to exp_c
    } step_t;

    localparam int unsigned MODE_CONT_BIT  = 0;
    localparam int unsigned MODE_BLEAD_BIT = 1;
    localparam int unsigned NUM_STEPS      = 4;

    // a-leads table; b-leads swaps a and b (only visible on the two hold steps).
    function automatic step_t step_lookup(input logic [1:0] idx, input logic b_leads);
        step_t s;
        case (idx)
            2'd0:    s = '{a: 1'b1, b: 1'b0, exp_c: 1'b0, hold: 1'b1};
            2'd1:    s = '{a: 1'b1, b: 1'b1, exp_c: 1'b1, hold: 1'b0};
            2'd2:    s = '{a: 1'b0, b: 1'b1, exp_c: 1'b1, hold: 1'b1};
            default: s = '{a: 1'b0, b: 1'b0, exp_c: 1'b0, hold: 1'b0};
        endcase
        if (b_leads) begin
            s = '{a: s.b, b: s.a, exp_c: s.exp_c, hold: s.hold};
        end
        return s;
    endfunction

endpackage

// File: rtl/muller_c_sync.sv
// muller_c_sync
// STAGES-deep flop synchronizer for the asynchronous C-element output.
// Ports:
//   i_clk  in   clock
//   i_rst  in   asynchronous active-high reset, clears all stages to 0
//   i_d    in   asynchronous input
//   o_q    out  synchronized output
module muller_c_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/muller_c_driver.sv
// muller_c_driver
// Drives a Muller C-element through the 4-phase sequence 10,11,01,00 (or 01,11,10,00 in
// b-leads order), checks hold/transition behaviour of its synchronized output at each step
// and accumulates saturating pass/fail counts.
// Optional feature: define MULLER_C_DRIVER_TIMEOUT_EN to give transition steps a
// 2^TMO_W-1 cycle timeout; without it a transition step waits indefinitely.
// Ports:
//   wb_clk_i    in   clock
//   wb_rst_i    in   asynchronous active-high reset
//   start_i     in   level; registered rising edge launches a run
//   mode_i      in   [0] continuous, [1] b-leads order; sampled at launch
//   a_o, b_o    out  registered C-element inputs
//   c_i         in   asynchronous C-element output
//   busy_o      out  run active (DRIVE..END)
//   done_o      out  one-cycle pulse in END
//   err_o       out  sticky step failure, cleared at launch
//   pass_cnt_o  out  saturating count of passed steps
//   fail_cnt_o  out  saturating count of failed steps
module muller_c_driver
    import muller_c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SETTLE      = 4,
    parameter int unsigned TMO_W       = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    output logic             a_o,
    output logic             b_o,
    input  logic             c_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o
);

    // One counter serves both the settle window and, when built, the timeout.
    localparam int unsigned          WCNT_W      = (TMO_W > 8) ? TMO_W : 8;
    localparam logic [WCNT_W-1:0]    SETTLE_LAST = WCNT_W'(SETTLE - 1);
`ifdef MULLER_C_DRIVER_TIMEOUT_EN
    localparam logic [WCNT_W-1:0]    TMO_LAST    = WCNT_W'((64'd1 << TMO_W) - 64'd2);
`endif

    state_e             r_state, w_state_d;
    logic               r_start_q, r_start_qq;
    logic [1:0]         r_mode, w_mode_d;
    logic [1:0]         r_step, w_step_d;
    logic               r_a, w_a_d;
    logic               r_b, w_b_d;
    logic               r_ok, w_ok_d;
    logic               r_err, w_err_d;
    logic [WCNT_W-1:0]  r_wcnt, w_wcnt_d;
    logic [CNT_W-1:0]   r_pass, w_pass_d;
    logic [CNT_W-1:0]   r_fail, w_fail_d;

    logic  w_c_sync;
    logic  w_launch;
    logic  w_c_match;
    step_t w_step;

    muller_c_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk (wb_clk_i),
        .i_rst (wb_rst_i),
        .i_d   (c_i),
        .o_q   (w_c_sync)
    );

    assign w_launch  = r_start_q & ~r_start_qq;
    assign w_step    = step_lookup(r_step, r_mode[MODE_BLEAD_BIT]);
    assign w_c_match = (w_c_sync == w_step.exp_c);

    always_comb begin
        w_state_d = r_state;
        w_mode_d  = r_mode;
        w_step_d  = r_step;
        w_a_d     = r_a;
        w_b_d     = r_b;
        w_ok_d    = r_ok;
        w_err_d   = r_err;
        w_wcnt_d  = r_wcnt;
        w_pass_d  = r_pass;
        w_fail_d  = r_fail;

        unique case (r_state)
            StIdle: begin
                w_a_d = 1'b0;
                w_b_d = 1'b0;
                if (w_launch) begin
                    w_mode_d  = mode_i;
                    w_err_d   = 1'b0;
                    w_pass_d  = '0;
                    w_fail_d  = '0;
                    w_step_d  = 2'd0;
                    w_state_d = StDrive;
                end
            end

            StDrive: begin
                w_a_d     = w_step.a;
                w_b_d     = w_step.b;
                w_wcnt_d  = '0;
                w_ok_d    = 1'b1;
                w_state_d = StWait;
            end

            StWait: begin
                if (w_step.hold) begin
                    // Every sample in the window must match, including the last one.
                    w_ok_d = r_ok & w_c_match;
                    if (r_wcnt == SETTLE_LAST) begin
                        w_state_d = StCheck;
                    end else begin
                        w_wcnt_d = r_wcnt + WCNT_W'(1);
                    end
                end else if (w_c_match) begin
                    w_ok_d    = 1'b1;
                    w_state_d = StCheck;
                end else begin
`ifdef MULLER_C_DRIVER_TIMEOUT_EN
                    if (r_wcnt == TMO_LAST) begin
                        w_ok_d    = 1'b0;
                        w_state_d = StCheck;
                    end else begin
                        w_wcnt_d = r_wcnt + WCNT_W'(1);
                    end
`else
                    w_state_d = StWait;
`endif
                end
            end

            StCheck: begin
                if (r_ok) begin
                    w_pass_d = (r_pass == '1) ? r_pass : r_pass + CNT_W'(1);
                end else begin
                    w_fail_d = (r_fail == '1) ? r_fail : r_fail + CNT_W'(1);
                    w_err_d  = 1'b1;
                end
                if (r_step == 2'(NUM_STEPS - 1)) begin
                    if (r_mode[MODE_CONT_BIT] && r_start_q) begin
                        w_step_d  = 2'd0;
                        w_state_d = StDrive;
                    end else begin
                        w_state_d = StEnd;
                    end
                end else begin
                    w_step_d  = r_step + 2'd1;
                    w_state_d = StDrive;
                end
            end

            StEnd: begin
                w_a_d     = 1'b0;
                w_b_d     = 1'b0;
                w_state_d = StIdle;
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= StIdle;
            r_start_q  <= 1'b0;
            r_start_qq <= 1'b0;
            r_mode     <= 2'b00;
            r_step     <= 2'd0;
            r_a        <= 1'b0;
            r_b        <= 1'b0;
            r_ok       <= 1'b0;
            r_err      <= 1'b0;
            r_wcnt     <= '0;
            r_pass     <= '0;
            r_fail     <= '0;
        end else begin
            r_state    <= w_state_d;
            r_start_q  <= start_i;
            r_start_qq <= r_start_q;
            r_mode     <= w_mode_d;
            r_step     <= w_step_d;
            r_a        <= w_a_d;
            r_b        <= w_b_d;
            r_ok       <= w_ok_d;
            r_err      <= w_err_d;
            r_wcnt     <= w_wcnt_d;
            r_pass     <= w_pass_d;
            r_fail     <= w_fail_d;
        end
    end

    assign a_o        = r_a;
    assign b_o        = r_b;
    assign busy_o     = (r_state != StIdle);
    assign done_o     = (r_state == StEnd);
    assign err_o      = r_err;
    assign pass_cnt_o = r_pass;
    assign fail_cnt_o = r_fail;

endmodule
